// File: rtl/bch_encoder_serial_if.sv
// Handshake bundle for the serial BCH(15,7) encoder: message in, serial
// codeword bits out, plus the parallel codeword report.
interface bch_encoder_serial_if #(
    parameter int N = 15,
    parameter int K = 7
);
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_bit;
    logic         out_last;
    logic [N-1:0] cw_data;
    logic         cw_valid;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bit, out_last, cw_data, cw_valid
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bit, out_last, cw_data, cw_valid
    );
endinterface

// File: rtl/bch_encoder_serial.sv
// Systematic serial BCH(15,7) encoder: streams the message MSB first, then the
// 8 parity bits produced by an LFSR dividing m(x)*x^8 by g(x).
module bch_encoder_serial #(
    parameter int              N        = 15,
    parameter int              K        = 7,
    parameter logic [N-K:0]    GEN_POLY = 9'h1D1
) (
    input  logic               clk,
    input  logic               rst,
    bch_encoder_serial_if.slave bus
);
    localparam int P  = N - K;
    localparam int CW = $clog2((P > K) ? P : K);

    typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [K-1:0]   msg;
    logic [P-1:0]   par;
    logic [P-1:0]   par_snap;
    logic           fb;
    logic [P-1:0]   par_next;
    logic [CW-1:0]  next_idx;

    // Feedback uses the bit currently on the wire, so the LFSR step and the
    // transmitted bit always agree, even across stalls.
    assign fb       = bus.out_bit ^ par[P-1];
    assign par_next = {par[P-2:0], 1'b0} ^ ({P{fb}} & GEN_POLY[P-1:0]);
    assign next_idx = CW'(K - 2) - cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            msg           <= '0;
            par           <= '0;
            par_snap      <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_bit   <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.cw_data   <= '0;
            bus.cw_valid  <= 1'b0;
        end else begin
            bus.cw_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state         <= MSG;
                        msg           <= bus.in_data;
                        par           <= '0;
                        cnt           <= '0;
                        bus.in_ready  <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.out_bit   <= bus.in_data[K-1];
                        bus.out_last  <= 1'b0;
                    end
                end
                MSG: begin
                    if (bus.out_ready) begin
                        par <= par_next;
                        if (cnt == CW'(K - 1)) begin
                            state       <= PAR;
                            cnt         <= '0;
                            par_snap    <= par_next;
                            bus.out_bit <= par_next[P-1];
                        end else begin
                            cnt         <= cnt + 1'b1;
                            bus.out_bit <= msg[next_idx];
                        end
                    end
                end
                PAR: begin
                    // Parity drains MSB first; the snapshot keeps the full
                    // remainder for the parallel codeword report.
                    if (bus.out_ready) begin
                        par <= {par[P-2:0], 1'b0};
                        if (cnt == CW'(P - 1)) begin
                            state         <= IDLE;
                            cnt           <= '0;
                            bus.cw_data   <= {msg, par_snap};
                            bus.cw_valid  <= 1'b1;
                            bus.in_ready  <= 1'b1;
                            bus.out_valid <= 1'b0;
                            bus.out_bit   <= 1'b0;
                            bus.out_last  <= 1'b0;
                        end else begin
                            cnt          <= cnt + 1'b1;
                            bus.out_bit  <= par[P-2];
                            bus.out_last <= (cnt == CW'(P - 2));
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bch_encoder_serial.sv
// Directed bench for bch_encoder_serial: hand-computed codewords, stalls,
// back-to-back frames, mid-frame reset and an exhaustive GF(16) syndrome sweep.
module tb_bch_encoder_serial;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    bch_encoder_serial_if bus ();

    bch_encoder_serial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Long division of the whole 15-bit word by g(x); returns the 8-bit remainder.
    function automatic logic [7:0] remainderOf(input logic [14:0] word);
        logic [14:0] v;
        v = word;
        for (int i = 14; i >= 8; i--)
            if (v[i]) v = v ^ (15'h01D1 << (i - 8));
        return v[7:0];
    endfunction

    function automatic logic [14:0] refCodeword(input logic [6:0] m);
        return {m, remainderOf({m, 8'h00})};
    endfunction

    function automatic logic [3:0] alphaPow(input int e);
        logic [3:0] a;
        a = 4'b0001;
        for (int i = 0; i < (e % 15); i++)
            a = {a[2:0], 1'b0} ^ (a[3] ? 4'b0011 : 4'b0000);
        return a;
    endfunction

    function automatic logic [3:0] syndrome(input logic [14:0] c, input int power);
        logic [3:0] s;
        s = 4'h0;
        for (int i = 0; i < 15; i++)
            if (c[i]) s = s ^ alphaPow(power * i);
        return s;
    endfunction

    // Push one message and collect its 15 serial bits, optionally stalling
    // out_ready at random; stalled cycles must show unchanged bit/last.
    task automatic applyStimulus(input string tag, input logic [6:0] msg,
                                 input logic [14:0] expCw, input bit stall,
                                 output logic [14:0] seen);
        int   got;
        bit   prevStall;
        logic prevBit, prevLast;
        logic rdy, b, l;
        seen      = '0;
        got       = 0;
        prevStall = 1'b0;
        prevBit   = 1'b0;
        prevLast  = 1'b0;
        checkOutput({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = msg;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 7'($urandom);
        for (int cyc = 0; cyc < 200 && got < 15; cyc++) begin
            checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
            checkOutput({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
            checkOutput({tag, " cw_valid early"}, 32'(bus.cw_valid), 32'd0);
            b = bus.out_bit;
            l = bus.out_last;
            if (prevStall) begin
                checkOutput({tag, " stall bit"}, 32'(b), 32'(prevBit));
                checkOutput({tag, " stall last"}, 32'(l), 32'(prevLast));
            end
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rdy;
            @(negedge clk);
            if (rdy) begin
                seen = {seen[13:0], b};
                got++;
                checkOutput({tag, " out_last"}, 32'(l), 32'(got == 15));
            end
            prevStall = !rdy;
            prevBit   = b;
            prevLast  = l;
        end
        bus.out_ready = 1'b0;
        checkOutput({tag, " bit count"}, 32'(got), 32'd15);
        checkOutput({tag, " serial"}, 32'(seen), 32'(expCw));
        checkOutput({tag, " cw_valid"}, 32'(bus.cw_valid), 32'd1);
        checkOutput({tag, " cw_data"}, 32'(bus.cw_data), 32'(expCw));
        checkOutput({tag, " out_valid end"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, " cw_valid pulse"}, 32'(bus.cw_valid), 32'd0);
    endtask

    initial begin
        logic [14:0] seen;
        logic [14:0] seenFast;
        compared      = 0;
        mismatched    = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset out_bit", 32'(bus.out_bit), 32'd0);
        checkOutput("reset out_last", 32'(bus.out_last), 32'd0);
        checkOutput("reset cw_valid", 32'(bus.cw_valid), 32'd0);
        checkOutput("reset cw_data", 32'(bus.cw_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus("m01", 7'h01, 15'h01D1, 1'b0, seen);
        applyStimulus("m40", 7'h40, 15'h40E8, 1'b0, seen);
        applyStimulus("m7F", 7'h7F, 15'h7FFF, 1'b0, seen);
        applyStimulus("m00", 7'h00, 15'h0000, 1'b0, seen);
        applyStimulus("m55 fast", 7'h55, refCodeword(7'h55), 1'b0, seenFast);
        applyStimulus("m55 stall", 7'h55, refCodeword(7'h55), 1'b1, seen);
        checkOutput("m55 stall vs fast", 32'(seen), 32'(seenFast));

        // Back-to-back: in_valid held, exactly one idle bubble between frames.
        bus.in_valid  = 1'b1;
        bus.in_data   = 7'h01;
        bus.out_ready = 1'b1;
        for (int c = 0; c <= 32; c++) begin
            checkOutput("b2b out_valid", 32'(bus.out_valid), 32'((c % 16) != 0));
            checkOutput("b2b in_ready", 32'(bus.in_ready), 32'((c % 16) == 0));
            if (c == 1) bus.in_data = 7'h40;
            if (c == 16) begin
                checkOutput("b2b cw_valid 1", 32'(bus.cw_valid), 32'd1);
                checkOutput("b2b cw_data 1", 32'(bus.cw_data), 32'h01D1);
            end
            if (c == 32) begin
                checkOutput("b2b cw_valid 2", 32'(bus.cw_valid), 32'd1);
                checkOutput("b2b cw_data 2", 32'(bus.cw_data), 32'h40E8);
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;

        // Reset after the 10th output bit: abort without any codeword report.
        bus.in_valid  = 1'b1;
        bus.in_data   = 7'h2A;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst mid out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst mid in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst mid cw_valid", 32'(bus.cw_valid), 32'd0);
        checkOutput("rst mid out_last", 32'(bus.out_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput("post rst cw_valid", 32'(bus.cw_valid), 32'd0);
            checkOutput("post rst out_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.out_ready = 1'b0;
        applyStimulus("post rst m01", 7'h01, 15'h01D1, 1'b0, seen);

        // Every message: reference codeword, divisibility by g(x), S1 = S3 = 0.
        for (int m = 0; m < 128; m++) begin
            applyStimulus("exh", 7'(m), refCodeword(7'(m)), (m % 3) == 0, seen);
            checkOutput("exh remainder", 32'(remainderOf(seen)), 32'd0);
            checkOutput("exh S1", 32'(syndrome(seen, 1)), 32'd0);
            checkOutput("exh S3", 32'(syndrome(seen, 3)), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
